meta_arb_n_avlstrm: RTL and testbench
=====================================

META_ARB_N_AVLSTRM -- requirements
Module: meta_arb_n_avlstrm

Interface
REQ-001 The block SHALL have parameter NUM_IN, default 4, number of input channels (legal 2..8).
REQ-002 The block SHALL have parameter DWIDTH, default META_WIDTH, data width per channel.
REQ-003 The block SHALL have parameter DEPTH, default 512, entries per input FIFO (power of 2, >=4).
REQ-004 The block SHALL have parameter FULL_LEVEL, default 480, almost-full threshold (1..DEPTH-1).
REQ-005 The block SHALL have parameter ARB_MODE, default 1, where 0 is fixed priority (index 0 highest) and 1 is round-robin.
REQ-006 The block SHALL have port Clk, input, 1, the single clock.
REQ-007 The block SHALL have port Rst_n, input, 1, reset (asynchronous, active-low).
REQ-008 The block SHALL have port in_valid, input, NUM_IN, per-channel write strobe.
REQ-009 The block SHALL have port in_data, input, NUM_IN*DWIDTH, channel i at bits [i*DWIDTH +: DWIDTH].
REQ-010 The block SHALL have port in_almost_full, output, NUM_IN, per-channel backpressure (txFull semantics).
REQ-011 The block SHALL have port out_valid, output, 1, output data valid.
REQ-012 The block SHALL have port out_data, output, DWIDTH, granted entry.
REQ-013 The block SHALL have port out_ready, input, 1, downstream accept.
REQ-014 The block SHALL have port out_chan, output, $clog2(NUM_IN), source channel of out_data.
REQ-015 The block SHALL have port overflow, output, NUM_IN, sticky per-channel drop flag.

Function
REQ-016 Each channel SHALL own a DEPTH-entry FIFO written on every cycle in_valid[i]=1; in_almost_full is advisory and the FIFO SHALL NOT gate writes with it.
REQ-017 in_almost_full[i] SHALL be registered and high when FIFO i count >= FULL_LEVEL, updated one cycle after the count changes.
REQ-018 A write to a FIFO with count==DEPTH SHALL be discarded, with count unchanged and overflow[i] set until reset.
REQ-019 A simultaneous push and pop on one FIFO SHALL leave count unchanged, and both SHALL succeed even at count==DEPTH.
REQ-020 The output stage SHALL be a single register that loads when out_valid=0 or out_ready=1, and out_data/out_chan SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 On a load, the arbiter SHALL grant exactly one non-empty FIFO, pop it, and set out_valid=1; with all FIFOs empty, out_valid SHALL become 0.
REQ-022 Latency: an entry written in cycle n into an empty block with out_ready=1 SHALL appear with out_valid=1 in cycle n+2.
REQ-023 In ARB_MODE=0, the grant SHALL go to the lowest-index non-empty FIFO.
REQ-024 In ARB_MODE=1, a grant to channel g SHALL make channel (g+1) mod NUM_IN highest priority next, the pointer SHALL advance only on an actual grant, and the reset pointer SHALL be 0.
REQ-025 Per-channel order SHALL be preserved, and no entry SHALL be duplicated or lost except per REQ-018.
REQ-026 Sustained throughput SHALL be one entry per cycle while any FIFO is non-empty and out_ready=1.

Reset
REQ-027 Rst_n low SHALL asynchronously clear all FIFO counts and pointers, out_valid, out_data, out_chan, overflow, in_almost_full and the RR pointer to 0.
REQ-028 Reset asserted mid-transfer SHALL flush all queued and held entries, with none emitted after release.
REQ-029 The block SHALL ignore in_valid in the first cycle after Rst_n deasserts.

Configuration
REQ-030 With macro META_ARB_STATS_EN defined, the block SHALL add output stats_grant (NUM_IN*32), a free-running wrapping per-channel count of output-register loads from channel i, and output stats_drop (NUM_IN*32), a count of REQ-018 discards, both reset to 0.
REQ-031 Without META_ARB_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 A bench SHALL cover: NUM_IN=4, ARB_MODE=1, all 4 channels with 8 entries each, out_ready=1 -> outputs interleave channels 0,1,2,3,0,... for 32 consecutive cycles.
REQ-033 A bench SHALL cover: ARB_MODE=0, channels 0 and 2 continuously loaded -> only channel 0 is granted until FIFO 0 is empty, then channel 2.
REQ-034 A bench SHALL cover: DEPTH=16, FULL_LEVEL=12, out_ready=0, 17 writes on channel 1 -> in_almost_full[1]=1 one cycle after the 12th write, overflow[1]=1 after the 17th, and exactly 16 entries drain in order.
REQ-035 A bench SHALL cover: out_ready toggling 1,0,0,1 with pending data -> out_data/out_chan stable during the stall, and no entry lost or repeated.
REQ-036 A bench SHALL cover: Rst_n pulsed low with 5 entries queued and out_valid=1 -> out_valid=0 immediately, and out_valid stays 0 after release with no new input.
REQ-037 A bench SHALL cover: META_ARB_STATS_EN with 10 grants to channel 3 and 2 drops on channel 0 -> stats_grant[3]=10 and stats_drop[0]=2.

Source files
------------

// File: rtl/meta_arb_n_avlstrm.sv
// N-channel FIFO front end feeding a single registered output through a fixed-priority or round-robin arbiter.
// Optional per-channel grant/drop counters are enabled by defining META_ARB_STATS_EN.
`ifndef META_WIDTH
`define META_WIDTH 32
`endif

module meta_arb_n_avlstrm #(
   parameter int unsigned NUM_IN     = 4,
   parameter int unsigned DWIDTH     = `META_WIDTH,
   parameter int unsigned DEPTH      = 512,
   parameter int unsigned FULL_LEVEL = 480,
   parameter int unsigned ARB_MODE   = 1
) (
   input  logic                       Clk,
   input  logic                       Rst_n,
   input  logic [NUM_IN-1:0]          in_valid,
   input  logic [NUM_IN*DWIDTH-1:0]   in_data,
   output logic [NUM_IN-1:0]          in_almost_full,
   output logic                       out_valid,
   output logic [DWIDTH-1:0]          out_data,
   input  logic                       out_ready,
   output logic [$clog2(NUM_IN)-1:0]  out_chan,
   output logic [NUM_IN-1:0]          overflow
`ifdef META_ARB_STATS_EN
   ,
   output logic [NUM_IN*32-1:0]       stats_grant,
   output logic [NUM_IN*32-1:0]       stats_drop
`endif
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(NUM_IN);
   localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_AF  = (AW+1)'(FULL_LEVEL);

   logic [DWIDTH-1:0] mem_q [NUM_IN][DEPTH];
   logic [AW-1:0]     wr_ptr_q [NUM_IN];
   logic [AW-1:0]     rd_ptr_q [NUM_IN];
   logic [AW:0]       cnt_q [NUM_IN];
   logic [NUM_IN-1:0] af_q, ovf_q;
   logic              armed_q;
   logic              ov_q;
   logic [DWIDTH-1:0] data_q;
   logic [CW-1:0]     chan_q, rr_q;

   logic              load, any, found;
   logic [CW-1:0]     gnt;
   logic [NUM_IN-1:0] nonempty, push, pop, drop;

   // Arbitration scans from the base channel; a full FIFO still accepts a write when it is popped the same cycle.
   always_comb begin
      nonempty = '0;
      push     = '0;
      pop      = '0;
      drop     = '0;
      gnt      = '0;
      found    = 1'b0;
      for (int unsigned i = 0; i < NUM_IN; i++) nonempty[i] = (cnt_q[i] != '0);
      load = !ov_q || out_ready;
      any  = |nonempty;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         int unsigned idx;
         idx = ((ARB_MODE == 1) ? 32'(rr_q) : 32'd0) + k;
         if (idx >= NUM_IN) idx = idx - NUM_IN;
         if (!found && nonempty[idx]) begin
            found    = 1'b1;
            gnt      = CW'(idx);
            pop[idx] = load;
         end
      end
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (armed_q && in_valid[i]) begin
            if (cnt_q[i] == CNT_MAX && !pop[i]) drop[i] = 1'b1;
            else                                push[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      for (int unsigned i = 0; i < NUM_IN; i++)
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i*DWIDTH +: DWIDTH];
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         af_q    <= '0;
         ovf_q   <= '0;
         armed_q <= 1'b0;
         ov_q    <= 1'b0;
         data_q  <= '0;
         chan_q  <= '0;
         rr_q    <= '0;
      end else begin
         armed_q <= 1'b1;
         ovf_q   <= ovf_q | drop;
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            af_q[i] <= (cnt_q[i] >= CNT_AF);
            if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
            if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
            else if (pop[i] && !push[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
         end
         if (load) begin
            ov_q <= any;
            if (any) begin
               data_q <= mem_q[gnt][rd_ptr_q[gnt]];
               chan_q <= gnt;
               if (ARB_MODE == 1) rr_q <= (gnt == CW'(NUM_IN - 1)) ? '0 : gnt + 1'b1;
            end
         end
      end
   end

   assign in_almost_full = af_q;
   assign overflow       = ovf_q;
   assign out_valid      = ov_q;
   assign out_data       = data_q;
   assign out_chan       = chan_q;

`ifdef META_ARB_STATS_EN
   logic [31:0] sg_q [NUM_IN];
   logic [31:0] sd_q [NUM_IN];

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            sg_q[i] <= '0;
            sd_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (pop[i])  sg_q[i] <= sg_q[i] + 1'b1;
            if (drop[i]) sd_q[i] <= sd_q[i] + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_IN; g++) begin : g_stats
      assign stats_grant[g*32 +: 32] = sg_q[g];
      assign stats_drop[g*32 +: 32]  = sd_q[g];
   end
`endif

endmodule

// File: tb/tb_meta_arb_n_avlstrm.sv
// Bench for meta_arb_n_avlstrm: round-robin and fixed-priority instances checked against a queue-based model.
module tb_meta_arb_n_avlstrm;
   localparam int NI = 4;
   localparam int DW = 8;
   localparam int DP = 16;
   localparam int FL = 12;

   logic           Clk = 1'b0;
   logic           Rst_n;
   logic [NI-1:0]  in_valid;
   logic [NI*DW-1:0] in_data;
   logic           out_ready;
   logic [NI-1:0]  afw [2];
   logic           ovw [2];
   logic [DW-1:0]  odw [2];
   logic [1:0]     ocw [2];
   logic [NI-1:0]  ofw [2];
`ifdef META_ARB_STATS_EN
   logic [NI*32-1:0] sgw [2];
   logic [NI*32-1:0] sdw [2];
`endif

   always #5 Clk = ~Clk;

   meta_arb_n_avlstrm #(.NUM_IN(NI), .DWIDTH(DW), .DEPTH(DP), .FULL_LEVEL(FL), .ARB_MODE(1)) dut_rr (
      .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_almost_full(afw[0]), .out_valid(ovw[0]), .out_data(odw[0]), .out_ready(out_ready),
      .out_chan(ocw[0]), .overflow(ofw[0])
`ifdef META_ARB_STATS_EN
      , .stats_grant(sgw[0]), .stats_drop(sdw[0])
`endif
   );

   meta_arb_n_avlstrm #(.NUM_IN(NI), .DWIDTH(DW), .DEPTH(DP), .FULL_LEVEL(FL), .ARB_MODE(0)) dut_fp (
      .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_almost_full(afw[1]), .out_valid(ovw[1]), .out_data(odw[1]), .out_ready(out_ready),
      .out_chan(ocw[1]), .overflow(ofw[1])
`ifdef META_ARB_STATS_EN
      , .stats_grant(sgw[1]), .stats_drop(sdw[1])
`endif
   );

   // Model: index 0 is the round-robin instance, index 1 the fixed-priority one.
   logic [DW-1:0] mq [2][NI][$];
   bit            mov [2];
   logic [DW-1:0] mdat [2];
   int            mchan [2];
   int            mrr [2];
   bit [NI-1:0]   maf [2];
   bit [NI-1:0]   movf [2];
   int unsigned   mgr [2][NI];
   int unsigned   mdr [2][NI];
   bit            started;
   int            n_checks = 0;
   int            n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic void mclear();
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < NI; c++) begin
            mq[m][c].delete();
            mgr[m][c] = 0;
            mdr[m][c] = 0;
         end
         mov[m] = 1'b0;
         mdat[m] = '0;
         mchan[m] = 0;
         mrr[m] = 0;
         maf[m] = '0;
         movf[m] = '0;
      end
      started = 1'b0;
   endfunction

   function automatic void mstep(int m);
      int g;
      bit load;
      g = -1;
      load = !mov[m] || out_ready;
      for (int c = 0; c < NI; c++) maf[m][c] = (mq[m][c].size() >= FL);
      if (load) begin
         for (int k = 0; k < NI; k++) begin
            int c;
            c = (m == 0) ? (mrr[m] + k) % NI : k;
            if (g < 0 && mq[m][c].size() > 0) g = c;
         end
         if (g >= 0) begin
            mdat[m] = mq[m][g].pop_front();
            mchan[m] = g;
            mov[m] = 1'b1;
            mrr[m] = (g + 1) % NI;
            mgr[m][g]++;
         end else begin
            mov[m] = 1'b0;
         end
      end
      if (started) begin
         for (int c = 0; c < NI; c++) begin
            if (in_valid[c]) begin
               if (mq[m][c].size() < DP) mq[m][c].push_back(in_data[c*DW +: DW]);
               else begin
                  movf[m][c] = 1'b1;
                  mdr[m][c]++;
               end
            end
         end
      end
   endfunction

   task automatic compare(int m);
      string tag;
      tag = (m == 0) ? "rr" : "fp";
      chk({tag, ".out_valid"}, 32'(ovw[m]), 32'(mov[m]));
      if (mov[m]) begin
         chk({tag, ".out_data"}, 32'(odw[m]), 32'(mdat[m]));
         chk({tag, ".out_chan"}, 32'(ocw[m]), mchan[m]);
      end
      chk({tag, ".in_almost_full"}, 32'(afw[m]), 32'(maf[m]));
      chk({tag, ".overflow"}, 32'(ofw[m]), 32'(movf[m]));
`ifdef META_ARB_STATS_EN
      for (int c = 0; c < NI; c++) begin
         chk({tag, ".stats_grant"}, sgw[m][c*32 +: 32], mgr[m][c]);
         chk({tag, ".stats_drop"}, sdw[m][c*32 +: 32], mdr[m][c]);
      end
`endif
   endtask

   task automatic cycle();
      @(posedge Clk);
      if (!Rst_n) mclear();
      else begin
         mstep(0);
         mstep(1);
         started = 1'b1;
      end
      @(negedge Clk);
      compare(0);
      compare(1);
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      in_valid = '0;
      out_ready = 1'b0;
      #1;
      mclear();
      compare(0);
      compare(1);
      repeat (2) cycle();
      Rst_n = 1'b1;
      cycle();
   endtask

   task automatic put(int c, int d);
      in_valid = '0;
      in_valid[c] = 1'b1;
      in_data[c*DW +: DW] = DW'(d);
   endtask

   initial begin
      int rates[4];
      rates[0] = 10; rates[1] = 35; rates[2] = 70; rates[3] = 95;
      Rst_n = 1'b1;
      in_valid = '0;
      in_data = '0;
      out_ready = 1'b0;
      @(negedge Clk);
      do_reset();
      for (int m = 0; m < 2; m++) begin
         chk("reset.out_valid", 32'(ovw[m]), 32'd0);
         chk("reset.overflow", 32'(ofw[m]), 32'd0);
         chk("reset.almost_full", 32'(afw[m]), 32'd0);
      end

      // 8 entries on every channel with out_ready held high
      for (int cyc = 0; cyc < 36; cyc++) begin
         in_valid = (cyc < 8) ? '1 : '0;
         for (int c = 0; c < NI; c++) in_data[c*DW +: DW] = DW'(c * 16 + cyc);
         out_ready = 1'b1;
         cycle();
         if (cyc >= 1 && cyc <= 32) begin
            int k;
            k = cyc - 1;
            chk("rr_order.chan", 32'(ocw[0]), k % 4);
            chk("rr_order.data", 32'(odw[0]), (k % 4) * 16 + k / 4);
            chk("fp_order.chan", 32'(ocw[1]), k / 8);
            chk("fp_order.data", 32'(odw[1]), (k / 8) * 16 + k % 8);
         end
         if (cyc == 33) begin
            chk("rr_drained.out_valid", 32'(ovw[0]), 32'd0);
            chk("fp_drained.out_valid", 32'(ovw[1]), 32'd0);
         end
      end

      // Fill channel 1 past full behind a stalled output register
      do_reset();
      for (int it = 0; it < 37; it++) begin
         in_valid = '0;
         out_ready = (it >= 19);
         if (it == 0) put(0, 'hA0);
         else if (it >= 2 && it <= 18) put(1, 'h10 + it - 2);
         cycle();
         for (int m = 0; m < 2; m++) begin
            if (it == 13) chk("af_before", 32'(afw[m][1]), 32'd0);
            if (it == 14) chk("af_after", 32'(afw[m][1]), 32'd1);
            if (it == 17) chk("ovf_before", 32'(ofw[m][1]), 32'd0);
            if (it == 18) begin
               chk("ovf_after", 32'(ofw[m][1]), 32'd1);
               chk("stall.data", 32'(odw[m]), 32'hA0);
            end
            if (it >= 19 && it <= 34) begin
               chk("drain.chan", 32'(ocw[m]), 32'd1);
               chk("drain.data", 32'(odw[m]), 'h10 + it - 19);
            end
            if (it == 35) chk("drain.end", 32'(ovw[m]), 32'd0);
         end
      end

      // Reset with 5 queued entries and a held output, then input in the first cycle after release
      do_reset();
      for (int it = 0; it < 6; it++) begin
         put(2, 'h20 + it);
         cycle();
      end
      in_valid = '0;
      chk("pre_reset.out_valid", 32'(ovw[0]), 32'd1);
      Rst_n = 1'b0;
      #1;
      mclear();
      chk("async_reset.rr", 32'(ovw[0]), 32'd0);
      chk("async_reset.fp", 32'(ovw[1]), 32'd0);
      repeat (2) cycle();
      Rst_n = 1'b1;
      out_ready = 1'b1;
      put(3, 'h33);
      cycle();
      in_valid = '0;
      repeat (6) cycle();
      chk("post_reset.rr", 32'(ovw[0]), 32'd0);
      chk("post_reset.fp", 32'(ovw[1]), 32'd0);

      // Random traffic; the first stretch uses the 1,0,0,1 ready pattern
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int unsigned rate;
         if (i == 1700) do_reset();
         rate = rates[(i / 500) % 4];
         for (int c = 0; c < NI; c++) begin
            in_valid[c] = ($urandom_range(99) < rate);
            in_data[c*DW +: DW] = DW'($urandom);
         end
         out_ready = (i < 400) ? ((i % 4 == 0) || (i % 4 == 3)) : ($urandom_range(99) < 75);
         cycle();
      end

`ifdef META_ARB_STATS_EN
      do_reset();
      put(0, 1);
      cycle();
      in_valid = '0;
      cycle();
      for (int j = 0; j < 18; j++) begin
         put(0, j);
         cycle();
      end
      out_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         put(3, 'h30 + j);
         cycle();
      end
      in_valid = '0;
      repeat (40) cycle();
      for (int m = 0; m < 2; m++) begin
         chk("stats.grant3", sgw[m][3*32 +: 32], 32'd10);
         chk("stats.drop0", sdw[m][0 +: 32], 32'd2);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
